// File: rtl/mor1kx_dtlb_assoc_walker.sv
// mor1kx_dtlb_assoc_walker
// Set-associative data TLB with a two-level hardware page-table walker.
//
// Lookups are accepted when lookup_valid_i is high and the walker is idle.
// The result appears on the resp_* outputs exactly one cycle later. A
// translated miss on a load or store starts a page-table walk, provided
// ptbr_i is non-zero. The walk uses the walk_* reload port. A huge (L1)
// PTE or a present L2 PTE is written into the TLB in a one-cycle FILL state.
// The requester then re-issues the lookup.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   enable_i                  translation enable (0: paddr = vaddr)
//   flush_i                   invalidate all entries, abort any walk
//   ptbr_i                    page-table base [31:10], zero disables walking
//   lookup_*                  lookup request: vaddr, load/store, privilege
//   busy_o                    walker active, lookups not accepted
//   resp_*                    registered lookup response
//   walk_req_o/walk_addr_o    reload bus request and address
//   walk_ack_i/walk_data_i    reload data strobe and PTE
//   walk_fault_o              sticky walk fault, cleared by walk_fault_clear_i
//
// Optional feature: define MOR1KX_DTLB_PERF_COUNTERS_EN to add the
// perf_hit_o / perf_miss_o response counters.

module mor1kx_dtlb_assoc_walker #(
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int OPTION_TLB_WAYS      = 2,
  parameter int OPTION_TLB_SET_WIDTH = 4,
  parameter int OPTION_PAGE_BITS     = 13,
  parameter int OPTION_PTE_IDX_BITS  = 11
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            enable_i,
  input  logic                            flush_i,
  input  logic [OPTION_OPERAND_WIDTH-11:0] ptbr_i,
  input  logic                            lookup_valid_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] lookup_vaddr_i,
  input  logic                            lookup_load_i,
  input  logic                            lookup_store_i,
  input  logic                            supervisor_mode_i,
  output logic                            busy_o,
  output logic                            resp_valid_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] resp_paddr_o,
  output logic                            resp_cache_inhibit_o,
  output logic                            resp_miss_o,
  output logic                            resp_pagefault_o,
  output logic                            walk_req_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] walk_addr_o,
  input  logic                            walk_ack_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] walk_data_i,
  output logic                            walk_fault_o,
  input  logic                            walk_fault_clear_i
`ifdef MOR1KX_DTLB_PERF_COUNTERS_EN
  ,
  output logic [31:0]                     perf_hit_o,
  output logic [31:0]                     perf_miss_o
`endif
);

  localparam int AW    = OPTION_OPERAND_WIDTH;
  localparam int WAYS  = OPTION_TLB_WAYS;
  localparam int SW    = OPTION_TLB_SET_WIDTH;
  localparam int SETS  = 1 << SW;
  localparam int PB    = OPTION_PAGE_BITS;
  localparam int PIB   = OPTION_PTE_IDX_BITS;
  localparam int VPN_W = AW - PB;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic [VPN_W-1:0] tag;
    logic [VPN_W-1:0] ppn;
    logic             huge;
    logic             ure;
    logic             uwe;
    logic             sre;
    logic             swe;
    logic             ci;
  } entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_L1, ST_L2, ST_FILL} state_t;

  // TLB storage: valid bits and replacement pointers are reset, payload is not.
  logic       valid_reg [WAYS][SETS];
  entry_t     entry_reg [WAYS][SETS];
  logic [WAY_W-1:0] rr_reg [SETS];

  state_t           state_reg;
  logic             walk_req_reg;
  logic [AW-1:0]    walk_addr_reg;
  logic [VPN_W-1:0] walk_vpn_reg;
  logic [VPN_W-1:0] pte_ppn_reg;
  logic             pte_huge_reg;
  logic             pte_w_reg;
  logic             pte_u_reg;
  logic             pte_ci_reg;
  logic             walk_fault_reg;

  logic             resp_valid_reg, resp_valid_next;
  logic [AW-1:0]    resp_paddr_reg, resp_paddr_next;
  logic             resp_ci_reg, resp_ci_next;
  logic             resp_miss_reg, resp_miss_next;
  logic             resp_pf_reg, resp_pf_next;

  // ---------------------------------------------------------------- lookup
  logic [SW-1:0]    lk_set;
  logic [VPN_W-1:0] lk_vpn;
  entry_t           way_entry [WAYS];
  logic [WAYS-1:0]  way_hit;
  logic             hit;
  entry_t           hit_entry;

  assign lk_set = lookup_vaddr_i[PB+SW-1:PB];
  assign lk_vpn = lookup_vaddr_i[AW-1:PB];

  // Huge entries only compare the L1-index part of the VPN.
  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      assign way_entry[gi] = entry_reg[gi][lk_set];
      assign way_hit[gi]   = valid_reg[gi][lk_set] &
                             (way_entry[gi].huge ?
                              (way_entry[gi].tag[VPN_W-1:PIB] == lk_vpn[VPN_W-1:PIB]) :
                              (way_entry[gi].tag == lk_vpn));
    end
  endgenerate

  // Scan from the top so the lowest-numbered hitting way is the last assignment.
  always_comb begin
    hit       = 1'b0;
    hit_entry = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit       = 1'b1;
        hit_entry = way_entry[w];
      end
    end
  end

  logic accept;
  logic start_walk;

  assign busy_o     = (state_reg != ST_IDLE);
  assign accept     = lookup_valid_i & ~busy_o;
  assign start_walk = accept & enable_i & ~hit & (ptbr_i != '0) &
                      (lookup_load_i | lookup_store_i) & ~flush_i;

  always_comb begin
    resp_valid_next = accept;
    resp_paddr_next = '0;
    resp_ci_next    = 1'b0;
    resp_miss_next  = 1'b0;
    resp_pf_next    = 1'b0;
    if (accept) begin
      if (!enable_i) begin
        resp_paddr_next = lookup_vaddr_i;
      end else if (hit) begin
        resp_paddr_next = hit_entry.huge ?
                          {hit_entry.ppn[VPN_W-1:PIB], lookup_vaddr_i[PB+PIB-1:0]} :
                          {hit_entry.ppn, lookup_vaddr_i[PB-1:0]};
        resp_ci_next    = hit_entry.ci;
        resp_pf_next    = supervisor_mode_i ?
                          ((lookup_store_i & ~hit_entry.swe) | (lookup_load_i & ~hit_entry.sre)) :
                          ((lookup_store_i & ~hit_entry.uwe) | (lookup_load_i & ~hit_entry.ure));
      end else begin
        resp_miss_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_reg <= 1'b0;
      resp_paddr_reg <= '0;
      resp_ci_reg    <= 1'b0;
      resp_miss_reg  <= 1'b0;
      resp_pf_reg    <= 1'b0;
    end else begin
      resp_valid_reg <= resp_valid_next;
      resp_paddr_reg <= resp_paddr_next;
      resp_ci_reg    <= resp_ci_next;
      resp_miss_reg  <= resp_miss_next;
      resp_pf_reg    <= resp_pf_next;
    end
  end

  assign resp_valid_o         = resp_valid_reg;
  assign resp_paddr_o         = resp_paddr_reg;
  assign resp_cache_inhibit_o = resp_ci_reg;
  assign resp_miss_o          = resp_miss_reg;
  assign resp_pagefault_o     = resp_pf_reg;

  // ---------------------------------------------------------------- walker
  logic walk_abort;
  logic l1_invalid;
  logic walk_fault_set;
  logic unused_pte_bits;

  // Losing the enable, the page-table base or the TLB contents invalidates a walk.
  assign walk_abort     = flush_i | ~enable_i | (ptbr_i == '0);
  assign l1_invalid     = (walk_data_i[AW-1:PB] == '0);
  assign walk_fault_set = ~walk_abort & walk_ack_i &
                          (((state_reg == ST_L1) & l1_invalid) |
                           ((state_reg == ST_L2) & ~walk_data_i[10]));
  assign unused_pte_bits = ^{walk_data_i[12:11], walk_data_i[8], walk_data_i[5:2], walk_data_i[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      walk_req_reg   <= 1'b0;
      walk_addr_reg  <= '0;
      walk_vpn_reg   <= '0;
      pte_ppn_reg    <= '0;
      pte_huge_reg   <= 1'b0;
      pte_w_reg      <= 1'b0;
      pte_u_reg      <= 1'b0;
      pte_ci_reg     <= 1'b0;
      walk_fault_reg <= 1'b0;
    end else begin
      if (walk_fault_clear_i)
        walk_fault_reg <= 1'b0;
      else if (walk_fault_set)
        walk_fault_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (start_walk) begin
            state_reg     <= ST_L1;
            walk_req_reg  <= 1'b1;
            walk_addr_reg <= {ptbr_i, lookup_vaddr_i[AW-1:PB+PIB], 2'b00};
            walk_vpn_reg  <= lk_vpn;
          end
        end
        ST_L1: begin
          if (walk_abort) begin
            state_reg    <= ST_IDLE;
            walk_req_reg <= 1'b0;
          end else if (walk_ack_i) begin
            if (l1_invalid) begin
              state_reg    <= ST_IDLE;
              walk_req_reg <= 1'b0;
            end else if (walk_data_i[9]) begin
              state_reg    <= ST_FILL;
              walk_req_reg <= 1'b0;
              pte_ppn_reg  <= walk_data_i[AW-1:PB];
              pte_huge_reg <= 1'b1;
              pte_w_reg    <= walk_data_i[7];
              pte_u_reg    <= walk_data_i[6];
              pte_ci_reg   <= walk_data_i[1];
            end else begin
              state_reg     <= ST_L2;
              walk_addr_reg <= {walk_data_i[AW-1:PB], walk_vpn_reg[PIB-1:0], 2'b00};
            end
          end
        end
        ST_L2: begin
          if (walk_abort) begin
            state_reg    <= ST_IDLE;
            walk_req_reg <= 1'b0;
          end else if (walk_ack_i) begin
            walk_req_reg <= 1'b0;
            if (!walk_data_i[10]) begin
              state_reg <= ST_IDLE;
            end else begin
              state_reg    <= ST_FILL;
              pte_ppn_reg  <= walk_data_i[AW-1:PB];
              pte_huge_reg <= 1'b0;
              pte_w_reg    <= walk_data_i[7];
              pte_u_reg    <= walk_data_i[6];
              pte_ci_reg   <= walk_data_i[1];
            end
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          walk_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign walk_req_o   = walk_req_reg;
  assign walk_addr_o  = walk_addr_reg;
  assign walk_fault_o = walk_fault_reg;

  // ---------------------------------------------------------------- fill
  logic             do_fill;
  logic [SW-1:0]    fill_set;
  logic [WAY_W-1:0] victim;
  logic             all_valid;
  entry_t           new_entry;

  assign do_fill  = (state_reg == ST_FILL) & ~walk_abort;
  assign fill_set = walk_vpn_reg[SW-1:0];

  always_comb begin
    victim    = rr_reg[fill_set];
    all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_reg[w][fill_set]) begin
        victim    = WAY_W'(w);
        all_valid = 1'b0;
      end
    end
  end

  always_comb begin
    new_entry      = '0;
    new_entry.tag  = walk_vpn_reg;
    new_entry.ppn  = pte_ppn_reg;
    new_entry.huge = pte_huge_reg;
    new_entry.swe  = pte_w_reg;
    new_entry.sre  = 1'b1;
    new_entry.uwe  = pte_w_reg & pte_u_reg;
    new_entry.ure  = pte_u_reg;
    new_entry.ci   = pte_ci_reg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          valid_reg[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++)
        rr_reg[s] <= '0;
    end else if (flush_i) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++)
          valid_reg[w][s] <= 1'b0;
    end else if (do_fill) begin
      valid_reg[victim][fill_set] <= 1'b1;
      // The pointer only moves when a valid entry had to be evicted.
      if (all_valid)
        rr_reg[fill_set] <= (rr_reg[fill_set] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[fill_set] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill)
      entry_reg[victim][fill_set] <= new_entry;
  end

`ifdef MOR1KX_DTLB_PERF_COUNTERS_EN
  logic [31:0] perf_hit_reg;
  logic [31:0] perf_miss_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_hit_reg  <= '0;
      perf_miss_reg <= '0;
    end else if (flush_i) begin
      perf_hit_reg  <= '0;
      perf_miss_reg <= '0;
    end else if (resp_valid_reg && enable_i) begin
      if (resp_miss_reg)
        perf_miss_reg <= perf_miss_reg + 32'd1;
      else
        perf_hit_reg  <= perf_hit_reg + 32'd1;
    end
  end

  assign perf_hit_o  = perf_hit_reg;
  assign perf_miss_o = perf_miss_reg;
`endif

endmodule

// File: tb/tb_mor1kx_dtlb_assoc_walker.sv
// Directed testbench for mor1kx_dtlb_assoc_walker. Expected lookup results
// are queued when a lookup is driven and popped when the response strobe
// is sampled. Walker outputs are checked after each step.
module tb_mor1kx_dtlb_assoc_walker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic [21:0] ptbr = '0;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_vaddr = '0;
  logic        lookup_load = 1'b0;
  logic        lookup_store = 1'b0;
  logic        supervisor = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] resp_paddr;
  logic        resp_ci;
  logic        resp_miss;
  logic        resp_pf;
  logic        walk_req;
  logic [31:0] walk_addr;
  logic        walk_ack = 1'b0;
  logic [31:0] walk_data = '0;
  logic        walk_fault;
  logic        walk_fault_clear = 1'b0;
`ifdef MOR1KX_DTLB_PERF_COUNTERS_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  mor1kx_dtlb_assoc_walker dut (
    .clk                  (clk),
    .rst                  (rst),
    .enable_i             (enable),
    .flush_i              (flush),
    .ptbr_i               (ptbr),
    .lookup_valid_i       (lookup_valid),
    .lookup_vaddr_i       (lookup_vaddr),
    .lookup_load_i        (lookup_load),
    .lookup_store_i       (lookup_store),
    .supervisor_mode_i    (supervisor),
    .busy_o               (busy),
    .resp_valid_o         (resp_valid),
    .resp_paddr_o         (resp_paddr),
    .resp_cache_inhibit_o (resp_ci),
    .resp_miss_o          (resp_miss),
    .resp_pagefault_o     (resp_pf),
    .walk_req_o           (walk_req),
    .walk_addr_o          (walk_addr),
    .walk_ack_i           (walk_ack),
    .walk_data_i          (walk_data),
    .walk_fault_o         (walk_fault),
    .walk_fault_clear_i   (walk_fault_clear)
`ifdef MOR1KX_DTLB_PERF_COUNTERS_EN
    ,
    .perf_hit_o           (perf_hit),
    .perf_miss_o          (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        miss;
    logic [31:0] paddr;
    logic        ci;
    logic        pf;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one lookup at a negedge; the response is sampled one negedge later.
  // paddr/CI are only meaningful on a hit or with translation disabled.
  task automatic lookup(input string tag, input logic [31:0] va, input logic ld, input logic st,
                        input logic sup, input logic e_miss, input logic [31:0] e_pa,
                        input logic e_ci, input logic e_pf, input logic e_busy);
    exp_t e;
    e.miss = e_miss; e.paddr = e_pa; e.ci = e_ci; e.pf = e_pf;
    sb.push_back(e);
    lookup_valid = 1'b1; lookup_vaddr = va; lookup_load = ld; lookup_store = st; supervisor = sup;
    @(negedge clk);
    lookup_valid = 1'b0; lookup_load = 1'b0; lookup_store = 1'b0;
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, ".miss"}, 32'(resp_miss), 32'(e.miss));
      check({tag, ".pf"}, 32'(resp_pf), 32'(e.pf));
      if (!e.miss) begin
        check({tag, ".paddr"}, resp_paddr, e.paddr);
        check({tag, ".ci"}, 32'(resp_ci), 32'(e.ci));
      end
    end
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    $display("lookup %s va=%h ld=%0d st=%0d sup=%0d -> miss=%0d pa=%h ci=%0d pf=%0d busy=%0d",
             tag, va, ld, st, sup, resp_miss, resp_paddr, resp_ci, resp_pf, busy);
  endtask

  // Miss that launches a walk; checks the L1 request.
  task automatic start_walk(input string tag, input logic [31:0] va, input logic st,
                            input logic sup, input logic [31:0] l1_addr);
    lookup(tag, va, ~st, st, sup, 1'b1, 32'h0, 1'b0, 1'b0, 1'b1);
    check({tag, ".l1_req"}, 32'(walk_req), 32'd1);
    check({tag, ".l1_addr"}, walk_addr, l1_addr);
  endtask

  task automatic ack(input string tag, input logic [31:0] data, input logic e_req,
                     input logic e_busy);
    walk_ack = 1'b1; walk_data = data;
    @(negedge clk);
    walk_ack = 1'b0;
    check({tag, ".req"}, 32'(walk_req), 32'(e_req));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
    $display("ack %s data=%h -> req=%0d addr=%h busy=%0d fault=%0d",
             tag, data, walk_req, walk_addr, busy, walk_fault);
  endtask

  // Two-level walk ending in a fill.
  task automatic walk2(input string tag, input logic [31:0] va, input logic [31:0] l1_addr,
                       input logic [31:0] l1_data, input logic [31:0] l2_addr,
                       input logic [31:0] l2_data);
    start_walk(tag, va, 1'b0, 1'b1, l1_addr);
    ack({tag, ".L1"}, l1_data, 1'b1, 1'b1);
    check({tag, ".l2_addr"}, walk_addr, l2_addr);
    ack({tag, ".L2"}, l2_data, 1'b0, 1'b1);
    @(negedge clk);
    check({tag, ".busy_drop"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.walk_req", 32'(walk_req), 32'd0);
    check("rst.walk_fault", 32'(walk_fault), 32'd0);
    check("rst.walk_addr", walk_addr, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Translation disabled: identity mapping
    lookup("bypass", 32'h1234_5678, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 1'b0);

    // Miss with walking disabled
    enable = 1'b1;
    lookup("nowalk", 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Full two-level walk
    ptbr = 22'h100;
    walk2("walk", 32'h0040_6004, 32'h0004_0000, 32'h0002_0000, 32'h0002_080C, 32'h1234_E4C2);
    lookup("walk.hit", 32'h0040_6004, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1234_E004, 1'b1, 1'b0, 1'b0);
    lookup("walk.ustore", 32'h0040_6004, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1234_E004, 1'b1, 1'b0, 1'b0);

    // Huge page: single request, then hit
    start_walk("huge", 32'h0012_3456, 1'b0, 1'b1, 32'h0004_0000);
    ack("huge.L1", 32'hAB00_2200, 1'b0, 1'b1);
    @(negedge clk);
    check("huge.busy_drop", 32'(busy), 32'd0);
    check("huge.one_req", 32'(walk_req), 32'd0);
    lookup("huge.hit", 32'h0012_3456, 1'b1, 1'b0, 1'b1, 1'b0, 32'hAB12_3456, 1'b0, 1'b0, 1'b0);
    lookup("huge.uload", 32'h0012_3456, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAB12_3456, 1'b0, 1'b1, 1'b0);

    // Permissions: W=1, U=0
    walk2("perm", 32'h0200_8010, 32'h0004_0008, 32'h0003_0000, 32'h0003_0010, 32'h5555_6480);
    lookup("perm.ustore", 32'h0200_8010, 1'b0, 1'b1, 1'b0, 1'b0, 32'h5555_6010, 1'b0, 1'b1, 1'b0);
    lookup("perm.sstore", 32'h0200_8010, 1'b0, 1'b1, 1'b1, 1'b0, 32'h5555_6010, 1'b0, 1'b0, 1'b0);

    // Non-present L2 PTE: sticky fault until cleared
    start_walk("fault", 32'h0300_A000, 1'b0, 1'b1, 32'h0004_000C);
    ack("fault.L1", 32'h0003_0000, 1'b1, 1'b1);
    check("fault.l2_addr", walk_addr, 32'h0003_0014);
    ack("fault.L2", 32'h1111_2000, 1'b0, 1'b0);
    check("fault.set", 32'(walk_fault), 32'd1);
    repeat (3) @(negedge clk);
    check("fault.held", 32'(walk_fault), 32'd1);
    walk_fault_clear = 1'b1;
    @(negedge clk);
    walk_fault_clear = 1'b0;
    check("fault.cleared", 32'(walk_fault), 32'd0);

    // Replacement in set 1 after a flush
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    walk2("repA", 32'h0100_2000, 32'h0004_0004, 32'h0004_0000, 32'h0004_0004, 32'hA000_0400);
    walk2("repB", 32'h0102_2000, 32'h0004_0004, 32'h0004_0000, 32'h0004_0044, 32'hB000_0400);
    walk2("repC", 32'h0104_2000, 32'h0004_0004, 32'h0004_0000, 32'h0004_0084, 32'hC000_0400);
    lookup("repA.evicted", 32'h0100_2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup("repB.hit", 32'h0102_2000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hB000_0000, 1'b0, 1'b0, 1'b0);
    lookup("repC.hit", 32'h0104_2000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    // Pointer now at way1: the next fill evicts B
    walk2("repD", 32'h0106_2000, 32'h0004_0004, 32'h0004_0000, 32'h0004_00C4, 32'hD000_0400);
    lookup("repB.evicted", 32'h0102_2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup("repC.kept", 32'h0104_2000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    lookup("repD.hit", 32'h0106_2000, 1'b0, 1'b0, 1'b1, 1'b0, 32'hD000_0000, 1'b0, 1'b0, 1'b0);

    // Flush during the L2 wait
    start_walk("flush", 32'h0108_2000, 1'b0, 1'b1, 32'h0004_0004);
    ack("flush.L1", 32'h0004_0000, 1'b1, 1'b1);
    check("flush.l2_addr", walk_addr, 32'h0004_0104);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush.req", 32'(walk_req), 32'd0);
    check("flush.busy", 32'(busy), 32'd0);
    check("flush.nofault", 32'(walk_fault), 32'd0);
    lookup("flush.C", 32'h0104_2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup("flush.D", 32'h0106_2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    lookup("flush.E", 32'h0108_2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-walk
    start_walk("arst", 32'h0040_6004, 1'b0, 1'b1, 32'h0004_0000);
    #2 rst = 1'b1;
    #1;
    check("arst.req", 32'(walk_req), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.addr", walk_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
